// File: rtl/gray_frame_ctrl.sv
// Frame sequencer for the RGB->gray pipeline: arms on start, gates data enable for one frame,
// counts gray output columns/rows, checks line length and drains pipeline latency.
// Optional GRAY_CTRL_STATS_EN adds frame-done and length-error counters.
//
//   state  | meaning
//   IDLE   | waiting for i_start
//   ARMED  | waiting for rising edge of i_v_sync
//   ACTIVE | data enable passed to gray stage, output stream counted
//   DRAIN  | waiting PIPE_LAT cycles for the last pixels to leave gray
module gray_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             iRST_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_v_sync,
    input  logic             i_data_en,
    input  logic             i_y_data_en,
    output logic             o_gray_en,
    output logic [CNT_W-1:0] o_col,
    output logic [CNT_W-1:0] o_row,
    output logic             o_busy,
    output logic             o_frame_done,
`ifdef GRAY_CTRL_STATS_EN
    output logic [15:0]      o_frame_cnt,
    output logic [15:0]      o_err_cnt,
`endif
    output logic             o_len_err
);

    localparam int DW = $clog2(PIPE_LAT + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic             vs_q, ye_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             len_err_q, len_err_d;

    logic             vs_rise, ye_fall, line_close, line_bad;
    logic [CNT_W-1:0] col_inc, row_inc;

`ifdef GRAY_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        drn_d      = drn_q;
        len_err_d  = len_err_q;
        done_d     = 1'b0;
        line_close = 1'b0;
        line_bad   = 1'b0;

        vs_rise = i_v_sync & ~vs_q;
        ye_fall = ye_q & ~i_y_data_en;
        col_inc = (i_y_data_en && (col_q != '1)) ? col_q + 1'b1 : col_q;
        row_inc = (row_q != '1) ? row_q + 1'b1 : row_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = ARMED;
                    len_err_d = 1'b0;
                end
            end
            ARMED: begin
                if (vs_rise) begin
                    state_d = ACTIVE;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ACTIVE: begin
                col_d = col_inc;
                // a line cut short by a new v_sync still counts as a (short) line
                line_close = ye_fall || (vs_rise && (col_inc != '0));
                if (line_close) begin
                    line_bad  = (col_inc != CNT_W'(H_ACTIVE));
                    len_err_d = len_err_q | line_bad;
                    row_d     = row_inc;
                    col_d     = '0;
                end
                if (vs_rise || (line_close && (row_inc == CNT_W'(V_ACTIVE)))) begin
                    state_d = DRAIN;
                    drn_d   = DW'(PIPE_LAT);
                end
            end
            DRAIN: begin
                if (drn_q <= DW'(1)) begin
                    state_d = IDLE;
                    drn_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // abort discards everything this cycle would have done, including a start
        if (i_abort) begin
            state_d   = IDLE;
            col_d     = col_q;
            row_d     = row_q;
            drn_d     = '0;
            len_err_d = len_err_q;
            done_d    = 1'b0;
            line_bad  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

`ifdef GRAY_CTRL_STATS_EN
    always_comb begin
        frame_cnt_d = done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
        err_cnt_d   = (line_bad && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;
`endif

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            drn_q     <= '0;
            vs_q      <= 1'b0;
            ye_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            drn_q     <= drn_d;
            vs_q      <= i_v_sync;
            ye_q      <= i_y_data_en;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
        end
    end

    // gate is combinational so the gray stage sees no extra latency
    assign o_gray_en    = (state_q == ACTIVE) & i_data_en & ~i_abort;
    assign o_col        = col_q;
    assign o_row        = row_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_len_err    = len_err_q;

endmodule
